// File: rtl/i2s_pkg.sv
// Shared types, default widths and framing helper for the I2S transmitter.
package i2s_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOP} i2s_tx_state_t;

  localparam int unsigned SAMPLE_W_DEF = 16;
  localparam int unsigned SLOT_W_DEF   = 32;

  // Word select is high one BCLK early so each edge precedes its slot's MSB.
  function automatic logic lr_from_bitcnt(input int unsigned bc, input int unsigned slot_w);
    return (bc >= slot_w - 1) && (bc <= 2 * slot_w - 2);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: toggles bclk every CLK_DIV clks while running, flags the falling edge.
module i2s_bclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic bclk,
  output logic fall_evt
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          tc;

  assign tc       = run && (div_cnt == DW'(CLK_DIV - 1));
  assign fall_evt = tc && bclk;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (run) begin
      if (tc) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: double hold registers, standard I2S framing, fresh/stale tracking.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned SLOT_W   = SLOT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_is_right,
  input  logic                       sample_valid,
  output logic                       bclk,
  output logic                       l_r_clk,
  output logic                       sdata,
  output logic                       underrun,
  output logic                       overrun,
  output logic                       busy
);

  localparam int unsigned     BC_W     = $clog2(2 * SLOT_W);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(2 * SLOT_W - 1);
  localparam logic [BC_W-1:0] BC_RIGHT = BC_W'(SLOT_W);

  i2s_tx_state_t state, state_next;

  logic [BC_W-1:0]     bit_cnt, bc_next;
  logic [SAMPLE_W-1:0] left_hold, right_hold, shift_reg;
  logic                left_fresh, right_fresh;
  logic                fall_evt, load_left, load_right, wr_left, wr_right;

  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (state != IDLE),
    .clear    (state == IDLE),
    .bclk     (bclk),
    .fall_evt (fall_evt)
  );

  always_comb begin
    bc_next    = (bit_cnt == BC_LAST) ? '0 : bit_cnt + 1'b1;
    load_left  = fall_evt && (bc_next == '0);
    load_right = fall_evt && (bc_next == BC_RIGHT);
    wr_left    = sample_valid && !sample_is_right;
    wr_right   = sample_valid && sample_is_right;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (enable) state_next = RUN;
      RUN:  if (!enable) state_next = STOP;
      STOP: begin
        if (enable)                                  state_next = RUN;
        else if (fall_evt && (bc_next == BC_LAST))   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      shift_reg   <= '0;
      left_hold   <= '0;
      right_hold  <= '0;
      left_fresh  <= 1'b0;
      right_fresh <= 1'b0;
      l_r_clk     <= 1'b0;
      sdata       <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
      busy     <= (state_next != IDLE);

      if (state == IDLE) begin
        if (state_next == RUN) bit_cnt <= BC_LAST;
      end else if (fall_evt) begin
        bit_cnt <= bc_next;
        l_r_clk <= lr_from_bitcnt(32'(bc_next), SLOT_W);
        // Shift register is pre-advanced on load; zeros shifted in cover the slot tail.
        if (load_left) begin
          sdata     <= left_hold[SAMPLE_W-1];
          shift_reg <= {left_hold[SAMPLE_W-2:0], 1'b0};
        end else if (load_right) begin
          sdata     <= right_hold[SAMPLE_W-1];
          shift_reg <= {right_hold[SAMPLE_W-2:0], 1'b0};
        end else begin
          sdata     <= shift_reg[SAMPLE_W-1];
          shift_reg <= {shift_reg[SAMPLE_W-2:0], 1'b0};
        end
        if (state_next == IDLE) begin
          l_r_clk <= 1'b0;
          sdata   <= 1'b0;
        end
      end

      if (load_left && !wr_left) begin
        left_fresh <= 1'b0;
        underrun   <= !left_fresh;
      end
      if (load_right && !wr_right) begin
        right_fresh <= 1'b0;
        underrun    <= !right_fresh;
      end

      // A write colliding with its own slot load wins the flag and suppresses both pulses.
      if (wr_left) begin
        left_hold  <= sample_in;
        left_fresh <= 1'b1;
        overrun    <= left_fresh && !load_left;
      end
      if (wr_right) begin
        right_hold  <= sample_in;
        right_fresh <= 1'b1;
        overrun     <= right_fresh && !load_right;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized bench for i2s_tx against a time-based frame model.
module tb_i2s_tx;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned SW      = 16;
  localparam int unsigned SLOT    = 32;
  localparam int unsigned BPER    = 2 * CLK_DIV;
  localparam int unsigned FRAME   = BPER * 2 * SLOT;

  logic clk = 1'b0;
  logic reset, enable, sample_is_right, sample_valid;
  logic [SW-1:0] sample_in;
  logic bclk, l_r_clk, sdata, underrun, overrun, busy;

  int n_vec = 0;
  int n_err = 0;
  int ur_cnt = 0;
  int or_cnt = 0;

  always #5 clk = ~clk;

  i2s_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_W(SW), .SLOT_W(SLOT)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .sample_in       (sample_in),
    .sample_is_right (sample_is_right),
    .sample_valid    (sample_valid),
    .bclk            (bclk),
    .l_r_clk         (l_r_clk),
    .sdata           (sdata),
    .underrun        (underrun),
    .overrun         (overrun),
    .busy            (busy)
  );

  // Model: position in the frame derived from clks elapsed since RUN entry.
  int          m_t;
  bit          m_run, m_stop;
  logic [SW-1:0] m_hold[2];
  logic [SW-1:0] m_cur[2];
  bit          m_fresh[2];
  bit          m_bclk, m_lr, m_sd, m_ur, m_or, m_busy;

  function automatic int m_bit(input int t);
    return ((t / BPER) + 2 * SLOT - 1) % (2 * SLOT);
  endfunction

  function automatic void model_edge();
    bit fall, ld, ldch;
    bit fr_old[2];
    int b, k;
    m_ur = 0;
    m_or = 0;
    if (reset) begin
      m_run = 0; m_stop = 0; m_t = 0;
      for (int i = 0; i < 2; i++) begin
        m_hold[i] = '0; m_cur[i] = '0; m_fresh[i] = 0;
      end
      m_bclk = 0; m_lr = 0; m_sd = 0; m_busy = 0;
      return;
    end
    fr_old = m_fresh;
    ld = 0;
    ldch = 0;
    if (m_run) begin
      m_t++;
      fall = (m_t % BPER == 0);
      b = m_bit(m_t);
      if (fall && (b == 0 || b == int'(SLOT))) begin
        ld = 1;
        ldch = (b == int'(SLOT));
      end
      if (ld) begin
        m_cur[ldch] = m_hold[ldch];
        if (!(sample_valid && sample_is_right == ldch)) begin
          if (!fr_old[ldch]) m_ur = 1;
          m_fresh[ldch] = 0;
        end
      end
      if (fall && b == int'(2 * SLOT - 1) && m_stop && !enable) m_run = 0;
      else m_stop = !enable;
      if (m_run) begin
        m_bclk = ((m_t / CLK_DIV) % 2) == 1;
        m_lr   = (b >= int'(SLOT) - 1) && (b <= int'(2 * SLOT) - 2);
        k      = b % int'(SLOT);
        m_sd   = (k < int'(SW)) ? m_cur[b >= int'(SLOT)][int'(SW) - 1 - k] : 1'b0;
      end else begin
        m_bclk = 0; m_lr = 0; m_sd = 0;
      end
    end else begin
      if (enable) begin
        m_run = 1; m_t = 0; m_stop = 0;
      end
      m_bclk = 0; m_lr = 0; m_sd = 0;
    end
    if (sample_valid) begin
      if (fr_old[sample_is_right] && !(ld && ldch == sample_is_right)) m_or = 1;
      m_hold[sample_is_right]  = sample_in;
      m_fresh[sample_is_right] = 1;
    end
    m_busy = m_run;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("bclk", 32'(bclk), 32'(m_bclk));
    check_eq("l_r_clk", 32'(l_r_clk), 32'(m_lr));
    check_eq("sdata", 32'(sdata), 32'(m_sd));
    check_eq("underrun", 32'(underrun), 32'(m_ur));
    check_eq("overrun", 32'(overrun), 32'(m_or));
    check_eq("busy", 32'(busy), 32'(m_busy));
    if (underrun === 1'b1) ur_cnt++;
    if (overrun === 1'b1) or_cnt++;
  endtask

  task automatic wr(input bit ch, input logic [SW-1:0] val);
    sample_valid = 1'b1;
    sample_is_right = ch;
    sample_in = val;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic run_cycles(input int n, input int odds);
    for (int i = 0; i < n; i++) begin
      if (odds != 0 && $urandom_range(odds - 1) == 0) begin
        sample_valid = 1'b1;
        sample_is_right = 1'($urandom_range(1));
        sample_in = SW'($urandom);
      end
      tick();
      sample_valid = 1'b0;
    end
  endtask

  task automatic wait_bit(input int target, output bit found);
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_run && m_bit(m_t) == target) begin
        found = 1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit found;
    int first_rise;
    int ur0, or0;
    logic [SW-1:0] lw, rw;

    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
    sample_is_right = 1'b0; sample_in = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    wr(1'b0, 16'hA5F0);
    wr(1'b1, 16'h0F0F);
    enable = 1'b1;
    tick();
    first_rise = -1;
    lw = '0;
    rw = '0;
    ur0 = ur_cnt;
    for (int i = 1; i <= 2 * int'(FRAME); i++) begin
      tick();
      if (i % BPER == 0 && i / BPER >= 1 && i / BPER <= int'(SW)) lw = {lw[SW-2:0], sdata};
      if (i % BPER == 0 && i / BPER >= int'(SLOT) + 1 && i / BPER <= int'(SLOT + SW))
        rw = {rw[SW-2:0], sdata};
      if (first_rise < 0 && l_r_clk === 1'b1) first_rise = i;
    end
    check_eq("left_word", 32'(lw), 32'h0000A5F0);
    check_eq("right_word", 32'(rw), 32'h00000F0F);
    check_eq("lr_first_rise", 32'(first_rise), 32'(SLOT * BPER));
    check_eq("underrun_frame2", 32'(ur_cnt - ur0), 32'd2);

    run_cycles(3 * FRAME, 40);

    wait_bit(2, found);
    check_eq("wait_left", 32'(found), 32'd1);
    or0 = or_cnt;
    wr(1'b0, 16'h1234);
    run_cycles(20, 0);
    wr(1'b0, 16'h8000);
    run_cycles(FRAME, 0);
    check_eq("overrun_double", 32'(or_cnt - or0), 32'd1);

    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_run && ((m_t + 1) % BPER == 0) && m_bit(m_t + 1) == int'(SLOT)) begin
        found = 1;
        break;
      end
      tick();
    end
    check_eq("wait_collision", 32'(found), 32'd1);
    ur0 = ur_cnt;
    or0 = or_cnt;
    wr(1'b1, 16'h7E57);
    check_eq("collision_pulses", 32'((ur_cnt - ur0) + (or_cnt - or0)), 32'd0);
    run_cycles(FRAME + 40, 0);

    wait_bit(10, found);
    check_eq("wait_stop_point", 32'(found), 32'd1);
    enable = 1'b0;
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (busy === 1'b0) begin
        found = 1;
        break;
      end
    end
    check_eq("busy_drop", 32'(found), 32'd1);
    run_cycles(50, 10);

    enable = 1'b1;
    run_cycles(300, 30);
    enable = 1'b0;
    run_cycles(100, 30);
    enable = 1'b1;
    run_cycles(FRAME + 100, 30);

    wait_bit(40, found);
    check_eq("wait_bit40", 32'(found), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_cycles(FRAME + 60, 25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
